// File: rtl/ling_pkg.sv
// Shared types for the chunked Ling adder: FSM state encoding, per-bit p/g/t bundle
// and the counter-width helper used by the top level.
package ling_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Per-bit propagate (xor), generate (and) and transmit (or) terms
    typedef struct packed {
        logic p;
        logic g;
        logic t;
    } pgt_t;

    // Width of a counter that spans 0..n-1; never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ling_chunk_unit.sv
// Combinational CHUNK-bit slice of the Ling adder. Runs the pseudo-carry recurrence
// h[i+1] = g[i] | (t[i-1] & h[i]) across the slice, seeded by the pseudo-carry and
// top-bit transmit of the previous slice, and recovers true carries c[i] = t[i-1] & h[i].
module ling_chunk_unit
    import ling_pkg::*;
#(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a_c,
    input  logic [CHUNK-1:0] b_c,
    input  logic             h_in,
    input  logic             t_in,
    output logic [CHUNK-1:0] s_c,
    output logic             h_out,
    output logic             t_out,
    output logic             c_msb,
    output logic             c_out
);

    pgt_t [CHUNK-1:0] pgt;
    logic [CHUNK:0]   h;
    logic [CHUNK-1:0] c;

    // Ripple the Ling pseudo-carry through the slice and form sum bits from true carries
    always_comb begin
        logic t_prev;
        pgt    = '0;
        h      = '0;
        c      = '0;
        s_c    = '0;
        t_prev = t_in;
        h[0]   = h_in;
        for (int i = 0; i < CHUNK; i++) begin
            pgt[i].g = a_c[i] & b_c[i];
            pgt[i].p = a_c[i] ^ b_c[i];
            pgt[i].t = a_c[i] | b_c[i];
            c[i]     = t_prev & h[i];
            h[i+1]   = pgt[i].g | c[i];
            s_c[i]   = pgt[i].p ^ c[i];
            t_prev   = pgt[i].t;
        end
    end

    assign h_out = h[CHUNK];
    assign t_out = pgt[CHUNK-1].t;
    assign c_msb = c[CHUNK-1];
    // True carry out of the slice: transmit of the top bit gates its pseudo-carry
    assign c_out = pgt[CHUNK-1].t & h[CHUNK];

endmodule

// File: rtl/ling_chunked_adder.sv
// Multi-cycle WIDTH-bit Ling adder: one CHUNK-bit slice per RUN cycle, valid/ready
// operand and result interfaces. Define LING_OVF_EN to add the signed-overflow
// output ovf, registered alongside cout.
module ling_chunked_adder
    import ling_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef LING_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = cnt_w(N);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("ling_chunked_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               h_q, t_q;
    logic               cout_q;
    logic               accept;
    logic               last;
    int                 off;
    logic [CHUNK-1:0]   a_chunk, b_chunk, s_chunk;
    logic               h_nxt, t_nxt, c_msb, c_top;

    assign accept = in_valid & in_ready;
    assign last   = (cnt_q == CNT_W'(N - 1));

    // Select the operand slice addressed by the chunk counter
    always_comb begin
        off     = int'(cnt_q) * CHUNK;
        a_chunk = a_q[off +: CHUNK];
        b_chunk = b_q[off +: CHUNK];
    end

    ling_chunk_unit #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_c   (a_chunk),
        .b_c   (b_chunk),
        .h_in  (h_q),
        .t_in  (t_q),
        .s_c   (s_chunk),
        .h_out (h_nxt),
        .t_out (t_nxt),
        .c_msb (c_msb),
        .c_out (c_top)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: a result take with a same-cycle accept goes straight back to RUN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last)   state_d = DONE;
            DONE: begin
                if (accept)         state_d = RUN;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state
    always_comb begin
        in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN);
    end

    // Operands are only captured on accept and need no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Ling seed, chunk counter and result assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q    <= 1'b0;
            t_q    <= 1'b1;
            cnt_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            h_q   <= cin;
            t_q   <= 1'b1;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            sum_q[off +: CHUNK] <= s_chunk;
            h_q                 <= h_nxt;
            t_q                 <= t_nxt;
            if (last) begin
                cnt_q  <= '0;
                cout_q <= c_top;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

`ifdef LING_OVF_EN
    logic ovf_q;

    // Signed overflow is the carry into the sign bit differing from the carry out of it
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (!accept && state_q == RUN && last) begin
            ovf_q <= c_msb ^ c_top;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_c_msb;
    assign unused_c_msb = c_msb;
`endif

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
